// File: rtl/adc_sport_capture.sv
// SPORT-side controller for a serial ADC: programs the control registers, then captures framed channel words.
// Define ADC_OVERRUN_CNT_EN to add the saturating overrun_cnt output.
module adc_sport_capture #(
   parameter int unsigned WORD_W = 16,
   parameter int unsigned N_CH   = 6,
   parameter int unsigned N_CFG  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SDOFS,
   input  logic              SDO,
   output logic              SDIFS,
   output logic              SDI,
   output logic              SE,
   input  logic              cfg_we,
   input  logic [3:0]        cfg_addr,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              start_prog,
   input  logic              sync,
   input  logic              continuous,
   input  logic [N_CH-1:0]   ch_mask,
   output logic              out_valid,
   output logic [WORD_W-1:0] out_data,
   output logic [2:0]        out_ch,
   input  logic              out_ready,
   output logic              busy,
   output logic              prog_done,
   output logic              frame_done,
   output logic              overrun
`ifdef ADC_OVERRUN_CNT_EN
   ,
   output logic [7:0]        overrun_cnt
`endif
);

   localparam int unsigned   BW       = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);
   localparam logic [2:0]    LAST_CH  = 3'(N_CH - 1);
   localparam logic [3:0]    LAST_IDX = 4'(N_CFG);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SEND, S_WAIT_FS, S_ARMED, S_ALIGN, S_CAPTURE, S_WAIT_CAP
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [WORD_W-1:0] r_cfg [0:N_CFG];
   logic [3:0]        r_idx;
   logic [2:0]        r_chcnt;
   logic [2:0]        r_ch;
   logic [WORD_W-1:0] r_shift;
   logic [BW-1:0]     r_bit;
   logic              r_out_valid;
   logic [WORD_W-1:0] r_out_data;
   logic [2:0]        r_out_ch;
   logic              r_prog_done;
   logic              r_frame_done;
   logic              r_overrun;

   logic              w_start;
   logic              w_bit_last;
   logic              w_ch_last;
   logic              w_count_ch;
   logic              w_cap_done;
   logic              w_mask_bit;
   logic              w_accept;
   logic              w_emit;
   logic              w_take;
   logic              w_ovr;
   logic [WORD_W-1:0] w_word;

   assign w_start    = start_prog && (r_state == S_IDLE || r_state == S_ARMED);
   assign w_bit_last = (r_bit == LAST_BIT);
   assign w_ch_last  = (r_ch == LAST_CH);
   assign w_count_ch = SDOFS && (r_state inside {S_ARMED, S_ALIGN, S_CAPTURE, S_WAIT_CAP});
   assign w_word     = {r_shift[WORD_W-2:0], SDO};
   assign w_cap_done = (r_state == S_CAPTURE) && w_bit_last;
   assign w_accept   = r_out_valid && out_ready;
   assign w_emit     = w_cap_done && w_mask_bit;
   assign w_take     = w_emit && (!r_out_valid || w_accept);
   assign w_ovr      = w_emit && r_out_valid && !out_ready;

   always_comb begin
      w_mask_bit = 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (r_ch == 3'(i)) w_mask_bit = ch_mask[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (start_prog) w_next = S_WAIT_FS;
         S_WAIT_FS: if (SDOFS) w_next = S_LOAD;
         S_LOAD:    w_next = S_SEND;
         S_SEND: begin
            if (w_bit_last) w_next = (r_idx == LAST_IDX) ? S_ARMED : S_WAIT_FS;
         end
         S_ARMED: begin
            if (start_prog) w_next = S_WAIT_FS;
            else if (sync)  w_next = S_ALIGN;
         end
         S_ALIGN:    if (SDOFS && r_chcnt == LAST_CH) w_next = S_WAIT_CAP;
         S_WAIT_CAP: if (SDOFS) w_next = S_CAPTURE;
         S_CAPTURE: begin
            // A completing word takes priority over a coincident frame sync.
            if (w_bit_last) begin
               if (w_ch_last) w_next = continuous ? S_WAIT_CAP : S_ARMED;
               else           w_next = S_WAIT_CAP;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i <= N_CFG; i++) r_cfg[i] <= '0;
         r_idx        <= '0;
         r_chcnt      <= '0;
         r_ch         <= '0;
         r_shift      <= '0;
         r_bit        <= '0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_ch     <= '0;
         r_prog_done  <= 1'b0;
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_prog_done  <= 1'b0;
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;

         if (cfg_we && cfg_addr <= LAST_IDX) r_cfg[cfg_addr] <= cfg_data;

         if (w_count_ch) r_chcnt <= (r_chcnt == LAST_CH) ? '0 : r_chcnt + 3'd1;

         if (w_accept) r_out_valid <= 1'b0;
         if (w_take) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_word;
            r_out_ch    <= r_ch;
         end
         if (w_ovr) r_overrun <= 1'b1;

         case (r_state)
            S_IDLE, S_ARMED: if (w_start) r_idx <= '0;
            S_LOAD: begin
               r_shift <= r_cfg[r_idx];
               r_bit   <= '0;
            end
            S_SEND: begin
               r_shift <= {r_shift[WORD_W-2:0], 1'b0};
               r_bit   <= r_bit + 1'b1;
               if (w_bit_last) begin
                  r_bit <= '0;
                  if (r_idx == LAST_IDX) r_prog_done <= 1'b1;
                  else                   r_idx       <= r_idx + 4'd1;
               end
            end
            S_WAIT_CAP: begin
               if (SDOFS) begin
                  r_ch  <= r_chcnt;
                  r_bit <= '0;
               end
            end
            S_CAPTURE: begin
               r_shift <= w_word;
               r_bit   <= r_bit + 1'b1;
               if (w_bit_last) begin
                  r_bit        <= '0;
                  r_frame_done <= w_ch_last;
               end else if (SDOFS) begin
                  r_ch  <= r_chcnt;
                  r_bit <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ADC_OVERRUN_CNT_EN
   logic [7:0] r_ovr_cnt;

   always_ff @(posedge clk) begin
      if (rst || start_prog)                 r_ovr_cnt <= '0;
      else if (w_ovr && r_ovr_cnt != 8'hFF) r_ovr_cnt <= r_ovr_cnt + 8'd1;
   end

   assign overrun_cnt = r_ovr_cnt;
`endif

   assign SDIFS      = (r_state == S_LOAD);
   assign SDI        = (r_state == S_SEND) && r_shift[WORD_W-1];
   assign SE         = 1'b1;
   assign busy       = !(r_state == S_IDLE || r_state == S_ARMED);
   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_ch     = r_out_ch;
   assign prog_done  = r_prog_done;
   assign frame_done = r_frame_done;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_adc_sport_capture.sv
// Directed self-checking bench for adc_sport_capture (default parameters, 16-bit words, 6 channels).
module tb_adc_sport_capture;

   logic        clk = 1'b0;
   logic        rst;
   logic        SDOFS;
   logic        SDO;
   logic        SDIFS;
   logic        SDI;
   logic        SE;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [15:0] cfg_data;
   logic        start_prog;
   logic        sync;
   logic        continuous;
   logic [5:0]  ch_mask;
   logic        out_valid;
   logic [15:0] out_data;
   logic [2:0]  out_ch;
   logic        out_ready;
   logic        busy;
   logic        prog_done;
   logic        frame_done;
   logic        overrun;
`ifdef ADC_OVERRUN_CNT_EN
   logic [7:0]  overrun_cnt;
`endif

   adc_sport_capture #(.WORD_W(16), .N_CH(6), .N_CFG(8)) dut (
      .clk(clk), .rst(rst), .SDOFS(SDOFS), .SDO(SDO), .SDIFS(SDIFS), .SDI(SDI), .SE(SE),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .start_prog(start_prog), .sync(sync), .continuous(continuous), .ch_mask(ch_mask),
      .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready),
      .busy(busy), .prog_done(prog_done), .frame_done(frame_done), .overrun(overrun)
`ifdef ADC_OVERRUN_CNT_EN
      , .overrun_cnt(overrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Monitor: collects control words seen on SDI and words accepted by the consumer.
   logic [15:0] sdi_q [$];
   logic [2:0]  och_q [$];
   logic [15:0] odat_q [$];
   int          sdifs_n = 0, prog_n = 0, frame_n = 0, ovr_n = 0, sdi_stray = 0, send_left = 0;
   logic [15:0] sdi_sh = '0;

   always @(negedge clk) begin
      if (send_left > 0) begin
         sdi_sh = {sdi_sh[14:0], SDI};
         send_left--;
         if (send_left == 0) sdi_q.push_back(sdi_sh);
      end else if (SDI === 1'b1) begin
         sdi_stray++;
      end
      if (SDIFS === 1'b1) begin
         sdifs_n++;
         send_left = 16;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         och_q.push_back(out_ch);
         odat_q.push_back(out_data);
      end
      if (prog_done === 1'b1)  prog_n++;
      if (frame_done === 1'b1) frame_n++;
      if (overrun === 1'b1)    ovr_n++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One ADC word: SDOFS cycle, 16 data bits MSB first, 15 idle cycles (32-cycle period).
   task automatic adc_word(input logic [15:0] w);
      SDOFS = 1'b1;
      SDO   = 1'b0;
      tick();
      SDOFS = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         SDO = w[i];
         tick();
      end
      SDO = 1'b0;
      repeat (15) tick();
   endtask

   task automatic pulse_sync();
      sync = 1'b1;
      tick();
      sync = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] base);
      for (int k = 0; k < 6; k++) adc_word(base + 16'(k));
   endtask

   task automatic check_out(input int idx, input logic [2:0] ch, input logic [15:0] d);
      check("out_index", 32'(och_q.size() > idx), 32'd1);
      if (och_q.size() > idx) begin
         check("out_ch", 32'(och_q[idx]), 32'(ch));
         check("out_data", 32'(odat_q[idx]), 32'(d));
      end
   endtask

   int o0, f0, v0, p0, s0, q0;
   logic saw_valid;

   initial begin
      rst = 1'b1; SDOFS = 1'b0; SDO = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      start_prog = 1'b0; sync = 1'b0; continuous = 1'b0; ch_mask = 6'b111111; out_ready = 1'b1;
      repeat (3) tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_ch", 32'(out_ch), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sdifs", 32'(SDIFS), 32'd0);
      check("rst_sdi", 32'(SDI), 32'd0);
      check("rst_se", 32'(SE), 32'd1);
      check("rst_pulses", 32'({prog_done, frame_done, overrun}), 32'd0);
      rst = 1'b0;

      // Programming: nine control words 0x1000..0x1008.
      for (int i = 0; i <= 8; i++) begin
         cfg_we = 1'b1; cfg_addr = 4'(i); cfg_data = 16'h1000 + 16'(i);
         tick();
      end
      cfg_we = 1'b0;
      start_prog = 1'b1;
      tick();
      start_prog = 1'b0;
      check("prog_busy", 32'(busy), 32'd1);
      s0 = sdifs_n; q0 = sdi_q.size(); p0 = prog_n;
      for (int i = 0; i <= 8; i++) adc_word(16'h5555);
      check("prog_sdifs_count", 32'(sdifs_n - s0), 32'd9);
      check("prog_words", 32'(sdi_q.size() - q0), 32'd9);
      for (int i = 0; i <= 8; i++) begin
         if (sdi_q.size() > q0 + i) check("prog_word", 32'(sdi_q[q0+i]), 32'h1000 + 32'(i));
      end
      check("prog_done_count", 32'(prog_n - p0), 32'd1);
      check("prog_armed_busy", 32'(busy), 32'd0);

      // Single frame, all channels enabled.
      o0 = och_q.size(); f0 = frame_n; v0 = ovr_n;
      pulse_sync();
      send_frame(16'h7000);
      send_frame(16'hA000);
      check("single_count", 32'(och_q.size() - o0), 32'd6);
      for (int k = 0; k < 6; k++) check_out(o0 + k, 3'(k), 16'hA000 + 16'(k));
      check("single_frame_done", 32'(frame_n - f0), 32'd1);
      check("single_overrun", 32'(ovr_n - v0), 32'd0);
      check("single_armed", 32'(busy), 32'd0);

      // Channel mask: only odd channels.
      ch_mask = 6'b101010;
      o0 = och_q.size(); f0 = frame_n;
      pulse_sync();
      send_frame(16'h7000);
      send_frame(16'hA000);
      check("mask_count", 32'(och_q.size() - o0), 32'd3);
      check_out(o0 + 0, 3'd1, 16'hA001);
      check_out(o0 + 1, 3'd3, 16'hA003);
      check_out(o0 + 2, 3'd5, 16'hA005);
      check("mask_frame_done", 32'(frame_n - f0), 32'd1);
      ch_mask = 6'b111111;

      // Backpressure: consumer stalled for the whole frame.
      out_ready = 1'b0;
      o0 = och_q.size(); f0 = frame_n; v0 = ovr_n;
      pulse_sync();
      send_frame(16'h7000);
      send_frame(16'hA000);
      check("bp_valid_held", 32'(out_valid), 32'd1);
      check("bp_data_held", 32'(out_data), 32'hA000);
      check("bp_ch_held", 32'(out_ch), 32'd0);
      check("bp_overruns", 32'(ovr_n - v0), 32'd5);
      check("bp_frame_done", 32'(frame_n - f0), 32'd1);
`ifdef ADC_OVERRUN_CNT_EN
      check("bp_overrun_cnt", 32'(overrun_cnt), 32'd5);
`endif
      out_ready = 1'b1;
      tick();
      check("bp_valid_cleared", 32'(out_valid), 32'd0);
      check_out(o0, 3'd0, 16'hA000);

      // Continuous: three frames from one sync.
      continuous = 1'b1;
      o0 = och_q.size(); f0 = frame_n;
      pulse_sync();
      send_frame(16'h7000);
      send_frame(16'hA000);
      send_frame(16'hB000);
      check("cont_busy_mid", 32'(busy), 32'd1);
      continuous = 1'b0;
      send_frame(16'hC000);
      check("cont_count", 32'(och_q.size() - o0), 32'd18);
      for (int k = 0; k < 6; k++) begin
         check_out(o0 + k, 3'(k), 16'hA000 + 16'(k));
         check_out(o0 + 6 + k, 3'(k), 16'hB000 + 16'(k));
         check_out(o0 + 12 + k, 3'(k), 16'hC000 + 16'(k));
      end
      check("cont_frame_done", 32'(frame_n - f0), 32'd3);
      check("cont_armed", 32'(busy), 32'd0);

      // Reset during the bit-7 capture cycle.
      o0 = och_q.size();
      pulse_sync();
      send_frame(16'h7000);
      SDOFS = 1'b1; SDO = 1'b0;
      tick();
      SDOFS = 1'b0;
      for (int i = 15; i >= 9; i--) begin
         SDO = i[0];
         tick();
      end
      SDO = 1'b1;
      rst = 1'b1;
      tick();
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_out_valid", 32'(out_valid), 32'd0);
      check("mrst_out_data", 32'(out_data), 32'd0);
      check("mrst_out_ch", 32'(out_ch), 32'd0);
      check("mrst_pulses", 32'({SDIFS, SDI, prog_done, frame_done, overrun}), 32'd0);
`ifdef ADC_OVERRUN_CNT_EN
      check("mrst_overrun_cnt", 32'(overrun_cnt), 32'd0);
`endif
      rst = 1'b0;
      saw_valid = 1'b0;
      for (int i = 0; i < 24; i++) begin
         SDO = i[0];
         tick();
         if (out_valid === 1'b1) saw_valid = 1'b1;
      end
      SDO = 1'b0;
      check("mrst_no_valid", 32'(saw_valid), 32'd0);
      check("mrst_no_outputs", 32'(och_q.size() - o0), 32'd0);

      // Register file cleared by reset; only the rewritten entry is non-zero.
      cfg_we = 1'b1; cfg_addr = 4'd4; cfg_data = 16'hBEEF;
      tick();
      cfg_we = 1'b0;
      start_prog = 1'b1;
      tick();
      start_prog = 1'b0;
      q0 = sdi_q.size(); p0 = prog_n;
      for (int i = 0; i <= 8; i++) adc_word(16'hFFFF);
      check("reprog_words", 32'(sdi_q.size() - q0), 32'd9);
      for (int i = 0; i <= 8; i++) begin
         if (sdi_q.size() > q0 + i) check("reprog_word", 32'(sdi_q[q0+i]), (i == 4) ? 32'hBEEF : 32'h0);
      end
      check("reprog_done", 32'(prog_n - p0), 32'd1);

      // start_prog and sync together in ARMED: programming restarts.
      start_prog = 1'b1; sync = 1'b1;
      tick();
      start_prog = 1'b0; sync = 1'b0;
      s0 = sdifs_n;
      adc_word(16'h0000);
      check("prio_sdifs", 32'(sdifs_n - s0), 32'd1);
      check("prio_busy", 32'(busy), 32'd1);
      check("sdi_idle_zero", 32'(sdi_stray), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
